option_queue_ctrl: RTL and testbench

- Circular option-queue controller between the board parser and the line solver.
- Buffers the parser's word stream (line-index header words, each followed by that line's candidate option words) and presents the head word first-word-fall-through.
- Recirculates the words the solver pushes back, and sequences the solve: load, start, run, then terminate on solved or on a full pass with no progress.

---
 rtl/option_queue_ctrl_if.sv | 40 ++++
 rtl/option_queue_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_option_queue_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/option_queue_ctrl_if.sv
// Handshake bundle between option_queue_ctrl and its parser/solver neighbours.
// The slave modport is the controller; the master modport is the parser/solver side.
interface option_queue_ctrl_if #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 2048,
    parameter int CNT_W  = $clog2(DEPTH + 1)
);
    logic              load_valid;
    logic [WORD_W-1:0] load_word;
    logic              load_last;
    logic              load_ready;
    logic              started;
    logic              pop;
    logic [WORD_W-1:0] pop_data;
    logic              pop_valid;
    logic              push;
    logic [WORD_W-1:0] push_data;
    logic              progress;
    logic              solved;
    logic              clear;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;
    logic              stuck;
    logic              busy;

    modport slave (
        input  load_valid, load_word, load_last, pop, push, push_data,
               progress, solved, clear,
        output load_ready, started, pop_data, pop_valid, count,
               overflow, underflow, stuck, busy
    );

    modport master (
        output load_valid, load_word, load_last, pop, push, push_data,
               progress, solved, clear,
        input  load_ready, started, pop_data, pop_valid, count,
               overflow, underflow, stuck, busy
    );
endinterface

// File: rtl/option_queue_ctrl.sv
// Circular option queue between board parser and line solver: buffers the parsed
// word stream, recirculates solver put-backs and ends the solve on victory or a dead pass.
module option_queue_ctrl #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 2048,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    option_queue_ctrl_if.slave q_if
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  pass_len_q, pass_len_d;
    logic [CNT_W-1:0]  pass_pops_q, pass_pops_d;
    logic              pass_prog_q, pass_prog_d;
    logic              started_q, started_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              stuck_q, stuck_d;
    logic              busy_q, busy_d;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic              full, empty;
    logic              pop_acc, push_acc;
    logic [CNT_W-1:0]  pops_inc;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        pass_len_d  = pass_len_q;
        pass_pops_d = pass_pops_q;
        pass_prog_d = pass_prog_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        stuck_d     = stuck_q;
        started_d   = 1'b0;
        wr_en       = 1'b0;
        wr_data     = q_if.load_word;
        pop_acc     = 1'b0;
        push_acc    = 1'b0;
        pops_inc    = pass_pops_q + CNT_ONE;

        if (q_if.clear) begin
            state_d     = S_IDLE;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            pass_len_d  = '0;
            pass_pops_d = '0;
            pass_prog_d = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            stuck_d     = 1'b0;
        end else begin
            case (state_q)
                // A last-marked first word starts the solve straight from IDLE.
                S_IDLE, S_LOAD: begin
                    if (q_if.load_valid) begin
                        if (!full) begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                            count_d  = count_q + CNT_ONE;
                            if (q_if.load_last) begin
                                state_d     = S_RUN;
                                started_d   = 1'b1;
                                pass_len_d  = count_d;
                                pass_pops_d = '0;
                                pass_prog_d = 1'b0;
                            end else begin
                                state_d = S_LOAD;
                            end
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    pop_acc  = q_if.pop && !empty;
                    push_acc = q_if.push && (!full || pop_acc);
                    if (q_if.pop && empty)     underflow_d = 1'b1;
                    if (q_if.push && !push_acc) overflow_d = 1'b1;
                    if (pop_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
                    if (push_acc) begin
                        wr_en    = 1'b1;
                        wr_data  = q_if.push_data;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                    count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
                    if (q_if.progress) pass_prog_d = 1'b1;
                    if (pop_acc)       pass_pops_d = pops_inc;

                    // An empty pass only survives if the solver refills the queue this cycle.
                    if (q_if.solved) begin
                        state_d = S_DONE;
                    end else if (pass_len_q == '0) begin
                        if (push_acc) begin
                            pass_len_d  = count_d;
                            pass_pops_d = '0;
                            pass_prog_d = 1'b0;
                        end else begin
                            stuck_d = 1'b1;
                            state_d = S_DONE;
                        end
                    end else if (pop_acc && (pops_inc == pass_len_q)) begin
                        if (!pass_prog_q && !q_if.progress) begin
                            stuck_d = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            pass_len_d  = count_d;
                            pass_pops_d = '0;
                            pass_prog_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            pass_len_q  <= '0;
            pass_pops_q <= '0;
            pass_prog_q <= 1'b0;
            started_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            stuck_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            pass_len_q  <= pass_len_d;
            pass_pops_q <= pass_pops_d;
            pass_prog_q <= pass_prog_d;
            started_q   <= started_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            stuck_q     <= stuck_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign q_if.load_ready = (state_q == S_IDLE) || ((state_q == S_LOAD) && !full);
    assign q_if.pop_valid  = (state_q == S_RUN) && !empty;
    assign q_if.pop_data   = empty ? '0 : mem_q[rd_ptr_q];
    assign q_if.started    = started_q;
    assign q_if.count      = count_q;
    assign q_if.overflow   = overflow_q;
    assign q_if.underflow  = underflow_q;
    assign q_if.stuck      = stuck_q;
    assign q_if.busy       = busy_q;
endmodule

// File: tb/tb_option_queue_ctrl.sv
// Bench for option_queue_ctrl (DEPTH=4): directed vector table, async reset case,
// then random traffic against a queue-based reference model.
module tb_option_queue_ctrl;
    localparam int WORD_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    option_queue_ctrl_if #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) q_if ();

    option_queue_ctrl #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .q_if    (q_if)
    );

    int checks = 0;
    int errors = 0;

    // in: {load_valid, load_last, pop, push, progress, solved, clear}
    // ef: {pop_valid, started, load_ready, overflow, underflow, stuck, busy}
    typedef struct {
        logic [6:0]  in;
        logic [15:0] lw;
        logic [15:0] pd;
        int          cnt;
        logic [15:0] epd;
        logic [6:0]  ef;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [6:0] in, input logic [15:0] lw, input logic [15:0] pd,
                                input int cnt, input logic [15:0] epd, input logic [6:0] ef);
        vec_t v;
        v.in = in; v.lw = lw; v.pd = pd; v.cnt = cnt; v.epd = epd; v.ef = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int cnt, input logic [15:0] epd, input logic [6:0] ef);
        chk({tag, " count"}, 32'(q_if.count), 32'(cnt));
        chk({tag, " pop_data"}, 32'(q_if.pop_data), 32'(epd));
        chk({tag, " flags"},
            32'({q_if.pop_valid, q_if.started, q_if.load_ready, q_if.overflow,
                 q_if.underflow, q_if.stuck, q_if.busy}), 32'(ef));
    endtask

    task automatic drive(input logic [6:0] in, input logic [15:0] lw, input logic [15:0] pd);
        {q_if.load_valid, q_if.load_last, q_if.pop, q_if.push,
         q_if.progress, q_if.solved, q_if.clear} = in;
        q_if.load_word = lw;
        q_if.push_data = pd;
    endtask

    // Reference model: the queue contents as an SV queue, a pass as "words left to pop".
    typedef enum int {M_IDLE, M_LOAD, M_RUN, M_DONE} mstate_t;
    logic [15:0] mq[$];
    mstate_t     m_st;
    bit          m_started, m_ovf, m_unf, m_stk, m_prog;
    int          m_left;

    task automatic m_reset();
        mq.delete();
        m_st = M_IDLE; m_started = 0; m_ovf = 0; m_unf = 0; m_stk = 0; m_prog = 0; m_left = 0;
    endtask

    task automatic m_enter_run();
        m_st = M_RUN; m_started = 1; m_left = mq.size(); m_prog = 0;
    endtask

    function automatic logic [15:0] m_pd();
        return (mq.size() > 0) ? mq[0] : 16'h0;
    endfunction

    function automatic logic [6:0] m_flags();
        bit rdy;
        rdy = (m_st == M_IDLE) || (m_st == M_LOAD && mq.size() < DEPTH);
        return {m_st == M_RUN && mq.size() > 0, m_started, rdy, m_ovf, m_unf, m_stk,
                m_st == M_LOAD || m_st == M_RUN};
    endfunction

    task automatic model_step(input logic [6:0] in, input logic [15:0] lw, input logic [15:0] pd);
        bit lv, ll, pp, ps, pg, sv, cl, did_pop, did_push;
        {lv, ll, pp, ps, pg, sv, cl} = in;
        m_started = 0;
        if (cl) begin
            mq.delete(); m_st = M_IDLE; m_ovf = 0; m_unf = 0; m_stk = 0;
            return;
        end
        case (m_st)
            M_IDLE, M_LOAD: if (lv) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(lw);
                    if (ll) m_enter_run(); else m_st = M_LOAD;
                end else m_ovf = 1;
            end
            M_RUN: begin
                did_pop  = pp && mq.size() > 0;
                did_push = ps && (mq.size() < DEPTH || did_pop);
                if (pp && !did_pop)  m_unf = 1;
                if (ps && !did_push) m_ovf = 1;
                if (did_pop)  void'(mq.pop_front());
                if (did_push) mq.push_back(pd);
                if (sv) m_st = M_DONE;
                else if (m_left == 0) begin
                    if (did_push) begin m_left = mq.size(); m_prog = 0; end
                    else begin m_stk = 1; m_st = M_DONE; end
                end else begin
                    if (did_pop) m_left--;
                    if (m_left == 0) begin
                        if (m_prog || pg) begin m_left = mq.size(); m_prog = 0; end
                        else begin m_stk = 1; m_st = M_DONE; end
                    end else if (pg) m_prog = 1;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [6:0] rin;
        logic [15:0] rlw, rpd;

        // recirculation, progress mid-pass, then a dead pass
        tbl.push_back(mk(7'b1000000, 16'h0003, 16'h0, 1, 16'h0003, 7'b0010001));
        tbl.push_back(mk(7'b1000000, 16'h0005, 16'h0, 2, 16'h0003, 7'b0010001));
        tbl.push_back(mk(7'b1100000, 16'h000A, 16'h0, 3, 16'h0003, 7'b1100001));
        tbl.push_back(mk(7'b0000000, 16'h0, 16'h0,    3, 16'h0003, 7'b1000001));
        tbl.push_back(mk(7'b0011000, 16'h0, 16'h0003, 3, 16'h0005, 7'b1000001));
        tbl.push_back(mk(7'b0011100, 16'h0, 16'h0005, 3, 16'h000A, 7'b1000001));
        tbl.push_back(mk(7'b0011000, 16'h0, 16'h000A, 3, 16'h0003, 7'b1000001));
        tbl.push_back(mk(7'b0011000, 16'h0, 16'h0003, 3, 16'h0005, 7'b1000001));
        tbl.push_back(mk(7'b0011000, 16'h0, 16'h0005, 3, 16'h000A, 7'b1000001));
        tbl.push_back(mk(7'b0011000, 16'h0, 16'h000A, 3, 16'h0003, 7'b0000010));
        tbl.push_back(mk(7'b0000001, 16'h0, 16'h0,    0, 16'h0,    7'b0010000));
        // load overflow
        tbl.push_back(mk(7'b1000000, 16'h0001, 16'h0, 1, 16'h0001, 7'b0010001));
        tbl.push_back(mk(7'b1000000, 16'h0002, 16'h0, 2, 16'h0001, 7'b0010001));
        tbl.push_back(mk(7'b1000000, 16'h0003, 16'h0, 3, 16'h0001, 7'b0010001));
        tbl.push_back(mk(7'b1000000, 16'h0004, 16'h0, 4, 16'h0001, 7'b0000001));
        tbl.push_back(mk(7'b1100000, 16'h0005, 16'h0, 4, 16'h0001, 7'b0001001));
        tbl.push_back(mk(7'b0000001, 16'h0, 16'h0,    0, 16'h0,    7'b0010000));
        // full RUN, drain to empty, underflow with refill
        tbl.push_back(mk(7'b1000000, 16'h0011, 16'h0, 1, 16'h0011, 7'b0010001));
        tbl.push_back(mk(7'b1000000, 16'h0022, 16'h0, 2, 16'h0011, 7'b0010001));
        tbl.push_back(mk(7'b1000000, 16'h0033, 16'h0, 3, 16'h0011, 7'b0010001));
        tbl.push_back(mk(7'b1100000, 16'h0044, 16'h0, 4, 16'h0011, 7'b1100001));
        tbl.push_back(mk(7'b0001000, 16'h0, 16'h0055, 4, 16'h0011, 7'b1001001));
        tbl.push_back(mk(7'b0011000, 16'h0, 16'h0066, 4, 16'h0022, 7'b1001001));
        tbl.push_back(mk(7'b0010000, 16'h0, 16'h0,    3, 16'h0033, 7'b1001001));
        tbl.push_back(mk(7'b0010000, 16'h0, 16'h0,    2, 16'h0044, 7'b1001001));
        tbl.push_back(mk(7'b0010100, 16'h0, 16'h0,    1, 16'h0066, 7'b1001001));
        tbl.push_back(mk(7'b0010100, 16'h0, 16'h0,    0, 16'h0,    7'b0001001));
        tbl.push_back(mk(7'b0011000, 16'h0, 16'h0007, 1, 16'h0007, 7'b1001101));
        tbl.push_back(mk(7'b0010000, 16'h0, 16'h0,    0, 16'h0,    7'b0001110));
        tbl.push_back(mk(7'b0000001, 16'h0, 16'h0,    0, 16'h0,    7'b0010000));
        // empty pass without refill
        tbl.push_back(mk(7'b1000000, 16'h0009, 16'h0, 1, 16'h0009, 7'b0010001));
        tbl.push_back(mk(7'b1100000, 16'h0008, 16'h0, 2, 16'h0009, 7'b1100001));
        tbl.push_back(mk(7'b0010100, 16'h0, 16'h0,    1, 16'h0008, 7'b1000001));
        tbl.push_back(mk(7'b0010000, 16'h0, 16'h0,    0, 16'h0,    7'b0000001));
        tbl.push_back(mk(7'b0010000, 16'h0, 16'h0,    0, 16'h0,    7'b0000110));
        tbl.push_back(mk(7'b0000001, 16'h0, 16'h0,    0, 16'h0,    7'b0010000));
        // solved, then pop ignored in DONE
        tbl.push_back(mk(7'b1000000, 16'h0021, 16'h0, 1, 16'h0021, 7'b0010001));
        tbl.push_back(mk(7'b1100000, 16'h0022, 16'h0, 2, 16'h0021, 7'b1100001));
        tbl.push_back(mk(7'b0000010, 16'h0, 16'h0,    2, 16'h0021, 7'b0000000));
        tbl.push_back(mk(7'b0010000, 16'h0, 16'h0,    2, 16'h0021, 7'b0000000));
        tbl.push_back(mk(7'b0000001, 16'h0, 16'h0,    0, 16'h0,    7'b0010000));
        // 3-word idle pass -> stuck on the 3rd pop
        tbl.push_back(mk(7'b1000000, 16'h000B, 16'h0, 1, 16'h000B, 7'b0010001));
        tbl.push_back(mk(7'b1000000, 16'h000C, 16'h0, 2, 16'h000B, 7'b0010001));
        tbl.push_back(mk(7'b1100000, 16'h000D, 16'h0, 3, 16'h000B, 7'b1100001));
        tbl.push_back(mk(7'b0011000, 16'h0, 16'h000B, 3, 16'h000C, 7'b1000001));
        tbl.push_back(mk(7'b0011000, 16'h0, 16'h000C, 3, 16'h000D, 7'b1000001));
        tbl.push_back(mk(7'b0011000, 16'h0, 16'h000D, 3, 16'h000B, 7'b0000010));
        tbl.push_back(mk(7'b0000001, 16'h0, 16'h0,    0, 16'h0,    7'b0010000));
        // solved outranks a dead pass in the same cycle
        tbl.push_back(mk(7'b1000000, 16'h0001, 16'h0, 1, 16'h0001, 7'b0010001));
        tbl.push_back(mk(7'b1100000, 16'h0002, 16'h0, 2, 16'h0001, 7'b1100001));
        tbl.push_back(mk(7'b0011000, 16'h0, 16'h0001, 2, 16'h0002, 7'b1000001));
        tbl.push_back(mk(7'b0011010, 16'h0, 16'h0002, 2, 16'h0001, 7'b0000000));
        tbl.push_back(mk(7'b0000001, 16'h0, 16'h0,    0, 16'h0,    7'b0010000));

        drive(7'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        check_outs("reset", 0, 16'h0, 7'b0010000);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].in, tbl[i].lw, tbl[i].pd);
            @(negedge clk);
            check_outs($sformatf("row%0d", i), tbl[i].cnt, tbl[i].epd, tbl[i].ef);
        end

        // async reset while loading with overflow already flagged
        for (int i = 0; i < 5; i++) begin
            drive(7'b1000000, 16'(16'h0030 + i), 16'h0);
            @(negedge clk);
        end
        check_outs("preload", 4, 16'h0030, 7'b0001001);
        drive(7'b0, 16'h0, 16'h0);
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 0, 16'h0, 7'b0010000);
        @(negedge clk);
        rst_n = 1'b1;

        m_reset();
        for (int c = 0; c < 4000; c++) begin
            check_outs($sformatf("rnd%0d", c), mq.size(), m_pd(), m_flags());
            rin[6] = ($urandom_range(0, 1) == 1);
            rin[5] = ($urandom_range(0, 5) == 0);
            rin[4] = ($urandom_range(0, 1) == 1);
            rin[3] = ($urandom_range(0, 1) == 1);
            rin[2] = ($urandom_range(0, 4) == 0);
            rin[1] = ($urandom_range(0, 59) == 0);
            rin[0] = (m_st == M_DONE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            rlw = 16'($urandom);
            rpd = 16'($urandom);
            drive(rin, rlw, rpd);
            model_step(rin, rlw, rpd);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
